// File: rtl/adc_spi_master.sv
// adc_spi_master: SPI master that moves one 16-bit frame per request to and from an ADC.
// It shifts the command word out on MOSI, MSB first, and collects the MISO word, MSB first.
// Every pin-facing output is a registered copy of the state from the previous cycle.
// As a result, CS_n and busy change one cycle after the start request is accepted.
//
// Ports:
//   clk        system clock (10 MHz)
//   rst        synchronous active-high reset
//   start_i    frame request, accepted only in IDLE
//   tx_data_i  command word, latched on the accepting edge
//   rx_data_o  last completed received word
//   busy_o     high while the FSM is not IDLE
//   done_o     one-cycle pulse at frame completion
//   sclk_o     serial clock, idles high
//   cs_n_o     active-low chip select
//   mosi_o     serial data to the ADC
//   miso_i     serial data from the ADC
module adc_spi_master #(
  parameter int unsigned CLK_DIV  = 1,
  parameter int unsigned CS_SETUP = 1,
  parameter int unsigned CS_HOLD  = 1,
  parameter int unsigned CS_IDLE  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [15:0] tx_data_i,
  output logic [15:0] rx_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        sclk_o,
  output logic        cs_n_o,
  output logic        mosi_o,
  input  logic        miso_i
);

  localparam int unsigned DW    = 16;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned BIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               phase_q, phase_d;   // 0: SCLK low phase, 1: SCLK high phase
  logic [DW-1:0]      tx_q, tx_d;
  logic [DW-1:0]      rx_q, rx_d;
  logic [DW-1:0]      rx_data_q, rx_data_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               sclk_q, sclk_d;
  logic               cs_n_q, cs_n_d;
  logic               mosi_q, mosi_d;
  logic               in_frame;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      phase_q   <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      sclk_q    <= 1'b1;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
    end
  end

  // Next-state logic and next values for the output registers
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    done_d    = 1'b0;
    in_frame  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SETUP;
          tx_d    = tx_data_i;
          cnt_d   = '0;
        end
      end
      ST_SETUP: begin
        in_frame = 1'b1;
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        in_frame = 1'b1;
        // The first high-phase cycle is the edge on which the SCLK pin rises.
        if (phase_q && (cnt_q == '0)) begin
          rx_d = {rx_q[DW-2:0], miso_i};
          if (bit_q != BIT_W'(DW - 1)) begin
            tx_d = {tx_q[DW-2:0], 1'b0};
          end
        end
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else if (bit_q == BIT_W'(DW - 1)) begin
            state_d = ST_HOLD;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            phase_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        in_frame = 1'b1;
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        // First gap cycle: publish the word and pulse done together with the CS_n rise.
        if (cnt_q == '0) begin
          rx_data_d = rx_q;
          done_d    = 1'b1;
        end
        if (cnt_q == CNT_W'(CS_IDLE - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_q != ST_IDLE);
    cs_n_d = !in_frame;
    sclk_d = !((state_q == ST_SHIFT) && !phase_q);
    // Take the post-shift word so that MOSI changes on the same edge as the SCLK rise.
    mosi_d = in_frame ? tx_d[DW-1] : 1'b0;
  end

  assign rx_data_o = rx_data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign sclk_o    = sclk_q;
  assign cs_n_o    = cs_n_q;
  assign mosi_o    = mosi_q;

endmodule

// File: tb/tb_adc_spi_master.sv
// tb_adc_spi_master: directed bench for adc_spi_master.
// It drives one instance with the default timing and a second instance with CLK_DIV=4.
// An ADC model changes MISO on SCLK falls and collects MOSI on those same falls.
`timescale 1ns/1ps
module tb_adc_spi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] tx_data = '0;
  logic [15:0] rx_data;
  logic        busy, done, sclk, cs_n, mosi;
  logic        miso = 1'b0;

  logic        start4 = 1'b0;
  logic [15:0] tx4 = '0;
  logic [15:0] rx_data4;
  logic        busy4, done4, sclk4, cs_n4, mosi4;
  logic        miso4 = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #50 clk = ~clk;

  adc_spi_master dut (
    .clk(clk), .rst(rst), .start_i(start), .tx_data_i(tx_data),
    .rx_data_o(rx_data), .busy_o(busy), .done_o(done), .sclk_o(sclk),
    .cs_n_o(cs_n), .mosi_o(mosi), .miso_i(miso)
  );

  adc_spi_master #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .start_i(start4), .tx_data_i(tx4),
    .rx_data_o(rx_data4), .busy_o(busy4), .done_o(done4), .sclk_o(sclk4),
    .cs_n_o(cs_n4), .mosi_o(mosi4), .miso_i(miso4)
  );

  // ADC model and pin monitor for the default instance
  logic [15:0] adc_word = '0;
  logic [15:0] adc_sh = '0;
  logic [15:0] mosi_word = '0;
  logic        sclk_prev = 1'b1, cs_prev = 1'b1;
  int cyc = 0, cs_low_len = 0, last_cs_low = 0, cs_high_len = 0, last_cs_high = 0;
  int fall_cnt = 0, rise_cnt = 0, bad_edges = 0, done_cnt = 0;
  int last_done_cyc = 0, done_gap = 0;

  always @(negedge clk) begin
    cyc++;
    if (cs_n === 1'b0) begin
      if (cs_prev === 1'b1) begin
        cs_low_len   = 1;
        last_cs_high = cs_high_len;
        fall_cnt     = 0;
        rise_cnt     = 0;
        mosi_word    = '0;
        adc_sh       = adc_word;
      end else begin
        cs_low_len++;
      end
    end else begin
      if (cs_prev === 1'b0) begin
        last_cs_low = cs_low_len;
        cs_high_len = 1;
      end else begin
        cs_high_len++;
      end
    end
    if (sclk_prev === 1'b1 && sclk === 1'b0) begin
      if (cs_n !== 1'b0 && !rst) bad_edges++;
      fall_cnt++;
      mosi_word = {mosi_word[14:0], mosi};
      miso      = adc_sh[15];
      adc_sh    = {adc_sh[14:0], 1'b0};
    end
    if (sclk_prev === 1'b0 && sclk === 1'b1) begin
      if (cs_n !== 1'b0 && !rst) bad_edges++;
      rise_cnt++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_gap      = cyc - last_done_cyc;
      last_done_cyc = cyc;
    end
    sclk_prev = sclk;
    cs_prev   = cs_n;
  end

  // Pin monitor for the CLK_DIV=4 instance
  logic sclk4_prev = 1'b1, cs4_prev = 1'b1;
  int cyc4 = 0, cs4_low_len = 0, last_cs4_low = 0, falls4 = 0, last_fall4 = 0, sclk4_period = 0;

  always @(negedge clk) begin
    cyc4++;
    if (cs_n4 === 1'b0) begin
      if (cs4_prev === 1'b1) begin
        cs4_low_len = 1;
        falls4      = 0;
      end else begin
        cs4_low_len++;
      end
    end else if (cs4_prev === 1'b0) begin
      last_cs4_low = cs4_low_len;
    end
    if (sclk4_prev === 1'b1 && sclk4 === 1'b0) begin
      falls4++;
      sclk4_period = cyc4 - last_fall4;
      last_fall4   = cyc4;
    end
    sclk4_prev = sclk4;
    cs4_prev   = cs_n4;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] w);
    @(posedge clk); #1 tx_data = w; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic launch4(input logic [15:0] w);
    @(posedge clk); #1 tx4 = w; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (done !== 1'b1 && n < limit);
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic wait_done4(input int limit);
    int n = 0;
    do begin @(negedge clk); n++; end while (done4 !== 1'b1 && n < limit);
    chk("done4_seen", 32'(done4), 32'd1);
  endtask

  task automatic wait_falls(input int k);
    int t = 0;
    while (fall_cnt < k && t < 200) begin @(posedge clk); #1; t++; end
    chk("fall_wait", 32'(fall_cnt >= k), 32'd1);
  endtask

  initial begin
    int n;
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd1);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_cs_n4", 32'(cs_n4), 32'd1);
    @(posedge clk); #1 rst = 1'b0;

    // Single frame with default timing
    adc_word = 16'h1ABC;
    launch(16'h8038);
    @(negedge clk);
    chk("e0_cs_n", 32'(cs_n), 32'd1);
    chk("e0_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("e1_cs_n", 32'(cs_n), 32'd0);
    chk("e1_busy", 32'(busy), 32'd1);
    wait_done(100, n);
    chk("latency", 32'(n + 1), 32'd35);
    chk("f1_rx_data", 32'(rx_data), 32'h1ABC);
    chk("f1_cs_n_at_done", 32'(cs_n), 32'd1);
    @(negedge clk);
    chk("f1_done_width", 32'(done), 32'd0);
    chk("f1_busy_gap", 32'(busy), 32'd1);
    @(negedge clk);
    chk("f1_busy_fall", 32'(busy), 32'd0);
    settle();
    chk("f1_mosi_word", 32'(mosi_word), 32'h8038);
    chk("f1_cs_low", 32'(last_cs_low), 32'd34);
    chk("f1_falls", 32'(fall_cnt), 32'd16);
    chk("f1_rises", 32'(rise_cnt), 32'd16);
    chk("f1_done_cnt", 32'(done_cnt), 32'd1);
    chk("f1_bad_edges", 32'(bad_edges), 32'd0);

    // Back-to-back frames with start held high
    repeat (3) @(posedge clk);
    #1 tx_data = 16'hAAA0; start = 1'b1;
    @(posedge clk); #1 tx_data = 16'h0000;
    wait_done(100, n);
    settle();
    chk("b2b_mosi_word1", 32'(mosi_word), 32'hAAA0);
    wait_done(100, n);
    start = 1'b0;
    settle();
    chk("b2b_done_gap", 32'(done_gap), 32'd37);
    chk("b2b_cs_high", 32'(last_cs_high), 32'd3);
    chk("b2b_mosi_word2", 32'(mosi_word), 32'h0000);
    chk("b2b_done_cnt", 32'(done_cnt), 32'd3);

    // Busy rejection: start pulse and tx_data change during bit 5
    repeat (4) @(posedge clk);
    launch(16'h8038);
    repeat (3) @(posedge clk);
    #1;
    wait_falls(6);
    tx_data = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(100, n);
    repeat (10) @(posedge clk);
    #1;
    chk("rej_mosi_word", 32'(mosi_word), 32'h8038);
    chk("rej_busy", 32'(busy), 32'd0);
    chk("rej_cs_n", 32'(cs_n), 32'd1);
    chk("rej_done_cnt", 32'(done_cnt), 32'd4);
    chk("rej_cs_low", 32'(last_cs_low), 32'd34);

    // Reset in the middle of bit 7
    chk("pre_rst_rx_data", 32'(rx_data), 32'h1ABC);
    launch(16'h1234);
    repeat (3) @(posedge clk);
    #1;
    wait_falls(8);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_cs_n", 32'(cs_n), 32'd1);
    chk("mid_rst_sclk", 32'(sclk), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rx_data", 32'(rx_data), 32'h0);
    chk("mid_rst_mosi", 32'(mosi), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_no_done", 32'(done_cnt), 32'd4);
    adc_word = 16'h0F0F;
    launch(16'h8038);
    wait_done(100, n);
    settle();
    chk("post_rst_rx_data", 32'(rx_data), 32'h0F0F);
    chk("post_rst_mosi_word", 32'(mosi_word), 32'h8038);
    chk("post_rst_cs_low", 32'(last_cs_low), 32'd34);
    chk("post_rst_done_cnt", 32'(done_cnt), 32'd5);

    // Boundary bits
    repeat (4) @(posedge clk);
    adc_word = 16'h8001;
    launch(16'h0001);
    wait_done(100, n);
    settle();
    chk("bnd_rx_data", 32'(rx_data), 32'h8001);
    chk("bnd_rx_msb", 32'(rx_data[15]), 32'd1);
    chk("bnd_rx_lsb", 32'(rx_data[0]), 32'd1);
    chk("bnd_mosi_word", 32'(mosi_word), 32'h0001);
    chk("bnd_rises", 32'(rise_cnt), 32'd16);
    chk("bnd_bad_edges", 32'(bad_edges), 32'd0);

    // Divider of 4 on the second instance
    miso4 = 1'b1;
    launch4(16'h0000);
    wait_done4(400);
    settle();
    chk("div4_rx_ones", 32'(rx_data4), 32'hFFFF);
    chk("div4_cs_low", 32'(last_cs4_low), 32'd130);
    chk("div4_sclk_period", 32'(sclk4_period), 32'd8);
    chk("div4_falls", 32'(falls4), 32'd16);
    miso4 = 1'b0;
    repeat (4) @(posedge clk);
    launch4(16'hFFFF);
    wait_done4(400);
    settle();
    chk("div4_rx_zeros", 32'(rx_data4), 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
